// File: rtl/dmem_mmio_bridge.sv
// Bridges the processor dmem port to the dmem syncram and decodes an 8-word MMIO page (TX FIFO, LED, cycle counter).
// Optional cycle counter: define CYCLE_COUNTER_EN to build it; otherwise offset 2 reads 0 and ignores writes.
module dmem_mmio_bridge #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE  = 12'hF00,
    parameter int          LED_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [11:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q_dmem,
    output logic [11:0]          mem_address,
    output logic [31:0]          mem_data,
    output logic                 mem_wren,
    input  logic [31:0]          mem_q,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [LED_WIDTH-1:0] led
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic                 w_isMmio;
    logic [2:0]           w_offset;
    logic                 w_mmioWr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pushOk;
    logic [31:0]          w_status;
    logic [31:0]          w_ledExt;
    logic [31:0]          w_mmioRd;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_rdPtr;
    logic [AW-1:0]        r_wrPtr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;
    logic [LED_WIDTH-1:0] r_led;

    assign w_isMmio    = (address_dmem[11:3] == MMIO_BASE[11:3]);
    assign w_offset    = address_dmem[2:0];
    assign w_mmioWr    = wren & w_isMmio;

    assign mem_address = address_dmem;
    assign mem_data    = data;
    assign mem_wren    = wren & ~w_isMmio;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign tx_valid = ~w_empty;
    assign tx_data  = tx_valid ? r_mem[r_rdPtr] : 8'h00;

    // A full FIFO still accepts a push when the head is leaving on the same edge.
    assign w_push   = w_mmioWr & (w_offset == 3'd0);
    assign w_pop    = tx_valid & tx_ready;
    assign w_pushOk = w_push & (~w_full | w_pop);

    always_ff @(posedge clock) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_pushOk) begin
                r_overflow <= 1'b1;
            end else if (w_mmioWr && (w_offset == 3'd3)) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led <= '0;
        end else if (w_mmioWr && (w_offset == 3'd1)) begin
            r_led <= data[LED_WIDTH-1:0];
        end
    end

    assign led = r_led;

`ifdef CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    // A write to CYCLE takes priority over the free-running increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (w_mmioWr && (w_offset == 3'd2)) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    always_comb begin
        w_status           = '0;
        w_status[31]       = r_overflow;
        w_status[8 +: CW]  = r_count;
        w_status[1]        = w_full;
        w_status[0]        = w_empty;
    end

    always_comb begin
        w_ledExt                = '0;
        w_ledExt[LED_WIDTH-1:0] = r_led;
    end

    always_comb begin
        w_mmioRd = '0;
        case (w_offset)
            3'd0:    w_mmioRd = w_status;
            3'd1:    w_mmioRd = w_ledExt;
`ifdef CYCLE_COUNTER_EN
            3'd2:    w_mmioRd = r_cycle;
`endif
            default: w_mmioRd = '0;
        endcase
    end

    assign q_dmem = w_isMmio ? w_mmioRd : mem_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge: expected TX bytes and read data are queued by the stimulus
// and popped by a negedge monitor; CYCLE_COUNTER_EN enables the counter checks.
module tb_dmem_mmio_bridge;

    logic        clock;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  led;

    logic        rdStrobe;
    logic [31:0] tbMem [4096];
    logic [7:0]  txQ [$];
    logic [31:0] rdQ [$];
    int          checks;
    int          failures;

    dmem_mmio_bridge dut (
        .clock(clock),
        .reset(reset),
        .address_dmem(address_dmem),
        .data(data),
        .wren(wren),
        .q_dmem(q_dmem),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .mem_q(mem_q),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .led(led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Simple dmem model with combinational read so q_dmem pass-through can be observed.
    always @(posedge clock) begin
        if (mem_wren) tbMem[mem_address] <= mem_data;
    end
    assign mem_q = tbMem[mem_address];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected TX bytes on handshakes and expected read data on read strobes.
    always @(negedge clock) begin
        if (reset && tx_valid && tx_ready) begin
            if (txQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL txUnexpected actual=0x%02h expected=none", tx_data);
            end else begin
                checkOutput("txByte", {24'h0, tx_data}, {24'h0, txQ.pop_front()});
            end
        end
        if (rdStrobe) begin
            if (rdQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rdUnexpected actual=0x%08h expected=none", q_dmem);
            end else begin
                checkOutput("readData", q_dmem, rdQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] wdata, input logic expWren);
        address_dmem = addr;
        data         = wdata;
        wren         = 1'b1;
        #1;
        checkOutput("memWren", {31'h0, mem_wren}, {31'h0, expWren});
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    task automatic applyRead(input logic [11:0] addr, input logic [31:0] expData);
        address_dmem = addr;
        wren         = 1'b0;
        rdQ.push_back(expData);
        rdStrobe     = 1'b1;
        @(posedge clock);
        #1;
        rdStrobe     = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b, input logic expected);
        if (expected) txQ.push_back(b);
        applyStimulus(12'hF00, {24'h0, b}, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        for (int i = 0; i < 4096; i++) tbMem[i] = 32'h0;
        reset        = 1'b0;
        address_dmem = 12'h000;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        rdStrobe     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset state
        checkOutput("rstTxValid", {31'h0, tx_valid}, 32'h0);
        checkOutput("rstTxData", {24'h0, tx_data}, 32'h0);
        checkOutput("rstLed", {24'h0, led}, 32'h0);
        applyRead(12'hF00, 32'h0000_0001);

        // Test 1: plain dmem pass-through
        applyStimulus(12'h010, 32'h0000_0123, 1'b1);
        applyRead(12'h010, 32'h0000_0123);
        checkOutput("t1Led", {24'h0, led}, 32'h0);
        checkOutput("t1TxValid", {31'h0, tx_valid}, 32'h0);

        // Page boundaries: 0xEFF and 0xF08 are ordinary memory
        applyStimulus(12'hEFF, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(12'hF08, 32'hCAFE_0008, 1'b1);
        applyRead(12'hEFF, 32'hDEAD_BEEF);
        applyRead(12'hF08, 32'hCAFE_0008);

        // Test 2: three bytes, then drain
        pushByte(8'h41, 1'b1);
        pushByte(8'h42, 1'b1);
        pushByte(8'h43, 1'b1);
        applyRead(12'hF00, 32'h0000_0300);
        checkOutput("t2TxData", {24'h0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tx_ready = 1'b0;
        checkOutput("t2Drained", {31'h0, tx_valid}, 32'h0);

        // Test 3: nine pushes into depth 8
        for (int i = 0; i < 9; i++) pushByte(8'h60 + 8'(i), (i < 8));
        applyRead(12'hF00, 32'h8000_0802);
        checkOutput("t3TxData", {24'h0, tx_data}, 32'h60);
        applyStimulus(12'hF03, 32'h0, 1'b0);
        applyRead(12'hF00, 32'h0000_0802);
        applyRead(12'hF03, 32'h0);

        // Test 4: push and pop on the same edge while full
        tx_ready = 1'b1;
        pushByte(8'h55, 1'b1);
        tx_ready = 1'b0;
        applyRead(12'hF00, 32'h0000_0802);
        tx_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        tx_ready = 1'b0;
        checkOutput("t4Drained", {31'h0, tx_valid}, 32'h0);

        // Test 5: LED register, plus unused offsets
        applyStimulus(12'hF01, 32'h0000_01A5, 1'b0);
        checkOutput("t5Led", {24'h0, led}, 32'hA5);
        applyRead(12'hF01, 32'h0000_00A5);
        applyStimulus(12'hF05, 32'hFFFF_FFFF, 1'b0);
        applyRead(12'hF05, 32'h0);

`ifdef CYCLE_COUNTER_EN
        // Test 6: cycle counter clear and count
        applyStimulus(12'hF02, 32'h0, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        applyRead(12'hF02, 32'd10);
`else
        applyStimulus(12'hF02, 32'h0, 1'b0);
        applyRead(12'hF02, 32'h0);
`endif

        // Mid-run asynchronous reset flushes the FIFO and clears state
        pushByte(8'h77, 1'b0);
        checkOutput("preRstValid", {31'h0, tx_valid}, 32'h1);
        address_dmem = 12'hF02;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstTxValid", {31'h0, tx_valid}, 32'h0);
        checkOutput("midRstTxData", {24'h0, tx_data}, 32'h0);
        checkOutput("midRstLed", {24'h0, led}, 32'h0);
        checkOutput("midRstCycle", q_dmem, 32'h0);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        applyRead(12'hF00, 32'h0000_0001);

        @(posedge clock);
        #1;
        checkOutput("txQEmpty", txQ.size(), 32'h0);
        checkOutput("rdQEmpty", rdQ.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
